sbd_digitized: RTL and testbench

SBD_DIGITIZED -- requirements
Module: sbd_digitized

---
 rtl/sbd_digitized_if.sv | 24 ++
 rtl/sbd_digitized.sv | 184 ++++++++++++++++++
 tb/tb_sbd_digitized.sv | 203 ++++++++++++++++++++
 3 files changed

// File: rtl/sbd_digitized_if.sv
// rtl/sbd_digitized_if.sv - request/result bundle for the digit-serial restoring divider
interface sbd_digitized_if #(
    parameter int SIZEA = 1142,
    parameter int SIZEB = 571
);
    logic             start;
    logic [SIZEA-1:0] a;
    logic [SIZEB-1:0] b;
    logic [SIZEB-1:0] q;
    logic [SIZEB-1:0] r;
    logic             busy;
    logic             done;
    logic             err;

    modport master (
        output start, a, b,
        input  q, r, busy, done, err
    );

    modport slave (
        input  start, a, b,
        output q, r, busy, done, err
    );
endinterface

// File: rtl/sbd_digitized.sv
// rtl/sbd_digitized.sv - restoring divider producing SIZEOF_DIGITS quotient bits per digit
module sbd_digitized #(
    parameter int SIZEA         = 1142,
    parameter int SIZEB         = 571,
    parameter int SIZEOF_DIGITS = 82,
    parameter int DIGITS        = 7
) (
    input  logic           clk,
    input  logic           rst,
    sbd_digitized_if.slave bus
);
    localparam int QW = DIGITS * SIZEOF_DIGITS;
    localparam int EW = QW + SIZEB;
    localparam int KW = $clog2(DIGITS + 1);
    localparam int JW = (SIZEOF_DIGITS > 1) ? $clog2(SIZEOF_DIGITS) : 1;

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_LOAD   = 3'd1;
    localparam logic [2:0] ST_RUN    = 3'd2;
    localparam logic [2:0] ST_STEP   = 3'd3;
    localparam logic [2:0] ST_OFFSET = 3'd4;
    localparam logic [2:0] ST_DONE   = 3'd5;

    logic [2:0]               state_q, state_d;
    logic [SIZEA-1:0]         a_q, a_d;
    logic [SIZEB-1:0]         b_q, b_d;
    logic                     err_flag_q, err_flag_d;
    logic [SIZEB-1:0]         rem_q, rem_d;
    logic [QW-1:0]            dvd_q, dvd_d;
    logic [SIZEB-1:0]         quo_q, quo_d;
    logic [SIZEOF_DIGITS-1:0] acc_q, acc_d;
    logic [KW-1:0]            k_q, k_d;
    logic [JW-1:0]            j_q, j_d;
    logic [SIZEB-1:0]         q_q, q_d;
    logic [SIZEB-1:0]         r_q, r_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;
    logic                     err_q, err_d;

    logic [SIZEB:0]           rem_shift;
    logic [SIZEB-1:0]         rem_sub;
    logic                     qbit;
    logic [EW-1:0]            a_ext;
    logic [QW-1:0]            quo_full;

    always_comb begin
        state_d    = state_q;
        a_d        = a_q;
        b_d        = b_q;
        err_flag_d = err_flag_q;
        rem_d      = rem_q;
        dvd_d      = dvd_q;
        quo_d      = quo_q;
        acc_d      = acc_q;
        k_d        = k_q;
        j_d        = j_q;
        q_d        = q_q;
        r_d        = r_q;
        busy_d     = busy_q;
        done_d     = 1'b0;
        err_d      = err_q;

        a_ext     = EW'(a_q);
        quo_full  = QW'(quo_q);
        rem_shift = {rem_q, dvd_q[QW-1]};
        qbit      = (rem_shift >= {1'b0, b_q});
        // The true difference is below b, so SIZEB bits hold it exactly.
        rem_sub   = rem_shift[SIZEB-1:0] - b_q;

        case (state_q)
            ST_IDLE: begin
                // The done cycle is still the tail of the previous operation.
                if (bus.start && !done_q) begin
                    a_d     = bus.a;
                    b_d     = bus.b;
                    busy_d  = 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: begin
                if (b_q == '0 || a_q[SIZEA-1:SIZEB] >= b_q) begin
                    err_flag_d = 1'b1;
                    state_d    = ST_DONE;
                end else begin
                    // High slice of the extended dividend is already below b
                    // and seeds the partial remainder; the rest streams in.
                    err_flag_d = 1'b0;
                    rem_d      = a_ext[EW-1:QW];
                    dvd_d      = a_ext[QW-1:0];
                    quo_d      = '0;
                    k_d        = '0;
                    state_d    = ST_RUN;
                end
            end
            ST_RUN: begin
                j_d     = '0;
                acc_d   = '0;
                state_d = ST_STEP;
            end
            ST_STEP: begin
                rem_d = qbit ? rem_sub : rem_shift[SIZEB-1:0];
                dvd_d = dvd_q << 1;
                acc_d = (acc_q << 1) | SIZEOF_DIGITS'(qbit);
                j_d   = j_q + 1'b1;
                if (j_q == JW'(SIZEOF_DIGITS - 1)) begin
                    state_d = ST_OFFSET;
                end
            end
            ST_OFFSET: begin
                for (int i = 0; i < DIGITS; i++) begin
                    if (k_q == KW'(i)) begin
                        quo_full[(DIGITS-1-i)*SIZEOF_DIGITS +: SIZEOF_DIGITS] = acc_q;
                    end
                end
                quo_d = SIZEB'(quo_full);
                k_d   = k_q + 1'b1;
                if (k_q == KW'(DIGITS - 1)) begin
                    state_d = ST_DONE;
                end else begin
                    state_d = ST_RUN;
                end
            end
            ST_DONE: begin
                done_d  = 1'b1;
                busy_d  = 1'b0;
                state_d = ST_IDLE;
                if (err_flag_q) begin
                    q_d   = '1;
                    r_d   = '0;
                    err_d = 1'b1;
                end else begin
                    q_d   = quo_q;
                    r_d   = rem_q;
                    err_d = 1'b0;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q    <= ST_IDLE;
            a_q        <= '0;
            b_q        <= '0;
            err_flag_q <= 1'b0;
            rem_q      <= '0;
            dvd_q      <= '0;
            quo_q      <= '0;
            acc_q      <= '0;
            k_q        <= '0;
            j_q        <= '0;
            q_q        <= '0;
            r_q        <= '0;
            busy_q     <= 1'b0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_q        <= a_d;
            b_q        <= b_d;
            err_flag_q <= err_flag_d;
            rem_q      <= rem_d;
            dvd_q      <= dvd_d;
            quo_q      <= quo_d;
            acc_q      <= acc_d;
            k_q        <= k_d;
            j_q        <= j_d;
            q_q        <= q_d;
            r_q        <= r_d;
            busy_q     <= busy_d;
            done_q     <= done_d;
            err_q      <= err_d;
        end
    end

    assign bus.q    = q_q;
    assign bus.r    = r_q;
    assign bus.busy = busy_q;
    assign bus.done = done_q;
    assign bus.err  = err_q;
endmodule

// File: tb/tb_sbd_digitized.sv
// tb/tb_sbd_digitized.sv - scoreboard bench for sbd_digitized
module tb_sbd_digitized;
    localparam int SIZEA  = 1142;
    localparam int SIZEB  = 571;
    localparam int SOD    = 82;
    localparam int DIGITS = 7;
    localparam int LAT_OK  = 2 + DIGITS * (SOD + 2);
    localparam int LAT_ERR = 2;

    typedef struct {
        logic [SIZEB-1:0] q;
        logic [SIZEB-1:0] r;
        logic             err;
        int               issue_cyc;
        int               lat;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;
    int   cyc = 0;
    int   done_cnt = 0;
    exp_t sb[$];
    exp_t last_exp;
    exp_t mon_e;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    sbd_digitized_if #(.SIZEA(SIZEA), .SIZEB(SIZEB)) bus();

    sbd_digitized #(
        .SIZEA(SIZEA), .SIZEB(SIZEB), .SIZEOF_DIGITS(SOD), .DIGITS(DIGITS)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    task automatic check(input string tag, input logic [SIZEB-1:0] got, input logic [SIZEB-1:0] want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0h want %0h", tag, got, want);
        end
    endtask

    function automatic logic [SIZEB-1:0] rnd_b();
        logic [575:0] t;
        for (int i = 0; i < 18; i++) t[i*32 +: 32] = $urandom;
        return t[SIZEB-1:0];
    endfunction

    function automatic exp_t model(input logic [SIZEA-1:0] a, input logic [SIZEB-1:0] b);
        exp_t e;
        logic [SIZEA-1:0] bw, qq, rr;
        bw = SIZEA'(b);
        e.issue_cyc = 0;
        if (b == '0 || a[SIZEA-1:SIZEB] >= b) begin
            e.q = '1; e.r = '0; e.err = 1'b1; e.lat = LAT_ERR;
        end else begin
            qq = a / bw;
            rr = a % bw;
            e.q = qq[SIZEB-1:0]; e.r = rr[SIZEB-1:0]; e.err = 1'b0; e.lat = LAT_OK;
        end
        return e;
    endfunction

    always @(negedge clk) begin
        if (bus.done) begin
            done_cnt++;
            if (sb.size() == 0) begin
                check("spurious_done", 1, 0);
            end else begin
                mon_e = sb.pop_front();
                last_exp = mon_e;
                check("q", bus.q, mon_e.q);
                check("r", bus.r, mon_e.r);
                check("err", bus.err, mon_e.err);
                check("latency", cyc - mon_e.issue_cyc - 1, mon_e.lat);
            end
        end
    end

    task automatic issue(input logic [SIZEA-1:0] a, input logic [SIZEB-1:0] b);
        exp_t e;
        @(negedge clk);
        bus.start = 1'b1; bus.a = a; bus.b = b;
        e = model(a, b);
        e.issue_cyc = cyc;
        sb.push_back(e);
        @(negedge clk);
        bus.start = 1'b0; bus.a = {rnd_b(), rnd_b()}; bus.b = rnd_b();
    endtask

    task automatic wait_done();
        int target;
        int n;
        target = done_cnt + 1;
        n = 0;
        while (done_cnt < target && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_timeout", (done_cnt >= target) ? 1 : 0, 1);
    endtask

    task automatic valid_op(input logic [SIZEB-1:0] bin);
        logic [SIZEB-1:0] b, hi;
        b = (bin == '0) ? SIZEB'(1) : bin;
        hi = rnd_b() % b;
        issue({hi, rnd_b()}, b);
        wait_done();
    endtask

    initial begin
        logic [SIZEB-1:0] bmax;
        logic [SIZEA-1:0] amax, ahi;
        int n;

        bus.start = 1'b0; bus.a = '0; bus.b = '0;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        check("rst_busy", bus.busy, 0);
        check("rst_done", bus.done, 0);
        check("rst_q", bus.q, 0);
        check("rst_r", bus.r, 0);
        check("rst_err", bus.err, 0);
        rst = 1'b0;

        issue(SIZEA'(1000), SIZEB'(7)); wait_done();
        issue({rnd_b(), rnd_b()}, '0); wait_done();
        ahi = SIZEA'(5) << SIZEB;
        issue(ahi, SIZEB'(5)); wait_done();
        bmax = '1;
        amax = SIZEA'(bmax) * SIZEA'(bmax);
        issue(amax, bmax); wait_done();
        issue('0, SIZEB'(3)); wait_done();
        valid_op(SIZEB'(1));
        valid_op(SIZEB'(3));
        for (int i = 0; i < 3; i++) valid_op(rnd_b());

        repeat (20) @(negedge clk);
        check("hold_q", bus.q, last_exp.q);
        check("hold_r", bus.r, last_exp.r);
        check("hold_err", bus.err, last_exp.err);
        check("idle_busy", bus.busy, 0);

        @(negedge clk);
        bus.start = 1'b1; bus.a = SIZEA'(1000); bus.b = SIZEB'(7); rst = 1'b1;
        @(negedge clk);
        bus.start = 1'b0; rst = 1'b0;
        check("rst_prio_busy", bus.busy, 0);
        check("rst_prio_q", bus.q, 0);

        issue(SIZEA'(1000), SIZEB'(7));
        repeat (298) @(negedge clk);
        check("mid_busy", bus.busy, 1);
        rst = 1'b1;
        sb.delete();
        @(negedge clk);
        rst = 1'b0;
        check("abort_busy", bus.busy, 0);
        check("abort_q", bus.q, 0);
        check("abort_r", bus.r, 0);
        check("abort_err", bus.err, 0);
        n = done_cnt;
        repeat (700) @(negedge clk);
        check("abort_no_done", done_cnt, n);
        issue(SIZEA'(1000), SIZEB'(7)); wait_done();

        n = done_cnt;
        issue({SIZEB'(2), rnd_b()}, SIZEB'(9));
        repeat (8) @(negedge clk);
        bus.start = 1'b1; bus.a = SIZEA'(77); bus.b = SIZEB'(4);
        @(negedge clk);
        bus.start = 1'b0;
        repeat (189) @(negedge clk);
        bus.start = 1'b1; bus.a = '0; bus.b = '0;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done();
        repeat (LAT_OK + 20) @(negedge clk);
        check("single_done", done_cnt, n + 1);

        issue(SIZEA'(1000), SIZEB'(7));
        n = 0;
        while (!bus.done && n < 2000) begin
            @(negedge clk);
            n++;
        end
        check("done_seen", bus.done, 1);
        bus.start = 1'b1; bus.a = SIZEA'(55); bus.b = SIZEB'(5);
        @(negedge clk);
        bus.start = 1'b0;
        check("start_in_done_ignored", bus.busy, 0);
        repeat (10) @(negedge clk);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
